// File: rtl/debounce_edge_if.sv
// ---------------------------------------------------------------------------
// debounce_edge_if
//
// Groups the data-side signals of the debounce_edge stage so that the stage
// and whatever drives it share one bundle.
//
//   D        synchronized raw level (from the upstream 2-flop synchronizer)
//   CLR_CNT  synchronous clear of EVT_CNT
//   Q        debounced level
//   RISE     one-cycle pulse when Q goes 0->1
//   FALL     one-cycle pulse when Q goes 1->0
//   EVT_CNT  wrapping count of RISE pulses
//
// master: the side that drives D/CLR_CNT and observes the results.
// slave : the debounce stage itself.
// ---------------------------------------------------------------------------
interface debounce_edge_if #(
    parameter int EVT_WIDTH = 8
);
    logic                 D;
    logic                 CLR_CNT;
    logic                 Q;
    logic                 RISE;
    logic                 FALL;
    logic [EVT_WIDTH-1:0] EVT_CNT;

    modport master (
        output D,
        output CLR_CNT,
        input  Q,
        input  RISE,
        input  FALL,
        input  EVT_CNT
    );

    modport slave (
        input  D,
        input  CLR_CNT,
        output Q,
        output RISE,
        output FALL,
        output EVT_CNT
    );
endinterface

// File: rtl/debounce_edge.sv
// ---------------------------------------------------------------------------
// debounce_edge
//
// Debounced level and edge-event stage for push-buttons and switches. The
// input D is already synchronized upstream; this block only qualifies it.
// A new level must be sampled on DEBOUNCE_CYCLES+1 consecutive edges before
// Q follows it. Each accepted change produces a single-cycle RISE or FALL
// pulse, and accepted rising edges are counted in a wrapping EVT_CNT.
//
// Ports:
//   CK   clock
//   RST  asynchronous, active-high reset
//   bus  debounce_edge_if.slave (D, CLR_CNT in; Q, RISE, FALL, EVT_CNT out)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles required after the first new-level sample
//                    (1 .. 2**CNT_WIDTH-1)
//   CNT_WIDTH        width of the stability counter
//   EVT_WIDTH        width of EVT_CNT (must match the interface)
// ---------------------------------------------------------------------------
module debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16,
    parameter int EVT_WIDTH       = 8
) (
    input  logic           CK,
    input  logic           RST,
    debounce_edge_if.slave bus
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // Counter value on the edge that completes qualification. The counter
    // restarts at 0 on the first new-level sample, so reaching this value
    // with the level still held means DEBOUNCE_CYCLES+1 samples in a row.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic                 q_q,     q_d;
    logic                 rise_q,  rise_d;
    logic                 fall_q,  fall_d;
    logic [EVT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;

    // Next-state logic. Pulses are computed here on the transition into a
    // stable state so that, once registered, they line up with the first
    // cycle Q shows the new level. Any sample at the old level while waiting
    // abandons the attempt without touching Q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            STABLE_LO: begin
                q_d = 1'b0;
                if (bus.D) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end

            WAIT_HI: begin
                if (!bus.D) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STABLE_HI: begin
                q_d = 1'b1;
                if (!bus.D) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end

            WAIT_LO: begin
                if (bus.D) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase
    end

    // Event counter. A clear wins over a simultaneous increment, so a RISE
    // that coincides with CLR_CNT is not counted.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (bus.CLR_CNT) begin
            evt_cnt_d = '0;
        end else if (rise_d) begin
            evt_cnt_d = evt_cnt_q + 1'b1;
        end
    end

    // All state and outputs are registered; reset aborts any qualification
    // in progress and drops every output immediately.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            q_q       <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign bus.Q       = q_q;
    assign bus.RISE    = rise_q;
    assign bus.FALL    = fall_q;
    assign bus.EVT_CNT = evt_cnt_q;

endmodule

// File: tb/tb_debounce_edge.sv
// ---------------------------------------------------------------------------
// tb_debounce_edge
//
// Directed scenarios followed by a randomized run, all checked against a
// reference model that works on run lengths of the sampled input: Q follows
// D once D has been sampled at a level different from Q on DEBOUNCE_CYCLES+1
// consecutive edges since reset or since D last changed.
// ---------------------------------------------------------------------------
module tb_debounce_edge;

    localparam int DC = 4;
    localparam int CW = 16;
    localparam int EW = 4;

    logic CK;
    logic RST;

    debounce_edge_if #(.EVT_WIDTH(EW)) bus ();

    debounce_edge #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_WIDTH      (CW),
        .EVT_WIDTH      (EW)
    ) dut (
        .CK (CK),
        .RST(RST),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic          m_q;
    logic          m_rise;
    logic          m_fall;
    logic [EW-1:0] m_evt;
    int            run;
    logic          last_d;

    // Free-running clock, period 10
    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Model reset: nothing has been sampled yet
    task automatic modelReset();
        m_q    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_evt  = '0;
        run    = 0;
        last_d = 1'b0;
    endtask

    // Model update for one active edge with the sampled inputs
    task automatic modelEdge(input logic d, input logic clr);
        if (run == 0 || d != last_d) run = 1;
        else if (run < 100000) run = run + 1;
        last_d = d;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (d != m_q && run >= DC + 1) begin
            m_q = d;
            if (d) m_rise = 1'b1;
            else   m_fall = 1'b1;
        end
        if (clr)         m_evt = '0;
        else if (m_rise) m_evt = m_evt + 1'b1;
    endtask

    // Compare all outputs against the model
    task automatic checkOutput(input string tag);
        checks++;
        assert ({bus.Q, bus.RISE, bus.FALL, bus.EVT_CNT} === {m_q, m_rise, m_fall, m_evt})
        else begin
            errors++;
            $error("[TB] FAIL %s: observed Q/RISE/FALL/EVT=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                   tag, bus.Q, bus.RISE, bus.FALL, bus.EVT_CNT, m_q, m_rise, m_fall, m_evt);
        end
    endtask

    // Compare one value against a directed constant
    task automatic checkValue(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Drive inputs, let one active edge sample them, then check at edge+1
    task automatic applyStimulus(input logic d, input logic clr, input string tag);
        bus.D       = d;
        bus.CLR_CNT = clr;
        @(posedge CK);
        modelEdge(d, clr);
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle, released on a falling edge
    task automatic doReset(input string tag);
        #2;
        RST = 1'b1;
        modelReset();
        #1;
        checkOutput(tag);
        @(negedge CK);
        RST = 1'b0;
    endtask

    // One clean press: rise after DC+1 high samples, fall after DC+1 low
    task automatic press(input string tag);
        for (int i = 0; i < DC + 2; i++) applyStimulus(1'b1, 1'b0, tag);
        for (int i = 0; i < DC + 2; i++) applyStimulus(1'b0, 1'b0, tag);
    endtask

    initial begin
        RST         = 1'b1;
        bus.D       = 1'b0;
        bus.CLR_CNT = 1'b0;
        modelReset();
        repeat (2) @(negedge CK);
        checkOutput("reset");
        checkValue("reset_q", 8'(bus.Q), 8'd0);
        RST = 1'b0;

        // 1: raise and hold D
        for (int i = 0; i < DC; i++) begin
            applyStimulus(1'b1, 1'b0, "t1_wait");
            checkValue("t1_q_low", 8'(bus.Q), 8'd0);
        end
        applyStimulus(1'b1, 1'b0, "t1_rise");
        checkValue("t1_q", 8'(bus.Q), 8'd1);
        checkValue("t1_rise", 8'(bus.RISE), 8'd1);
        checkValue("t1_evt", 8'(bus.EVT_CNT), 8'd1);
        applyStimulus(1'b1, 1'b0, "t1_after");
        checkValue("t1_rise_once", 8'(bus.RISE), 8'd0);

        // back to low
        for (int i = 0; i < DC + 2; i++) applyStimulus(1'b0, 1'b0, "t1_fall");
        checkValue("t1_q_back", 8'(bus.Q), 8'd0);

        // 2: highs one sample too short, three times
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DC; i++) begin
                applyStimulus(1'b1, 1'b0, "t2_glitch");
                checkValue("t2_no_rise", 8'(bus.RISE), 8'd0);
            end
            applyStimulus(1'b0, 1'b0, "t2_low");
            checkValue("t2_q", 8'(bus.Q), 8'd0);
        end
        checkValue("t2_evt", 8'(bus.EVT_CNT), 8'd1);

        // 3: fall from STABLE_HI
        for (int i = 0; i < DC + 2; i++) applyStimulus(1'b1, 1'b0, "t3_up");
        checkValue("t3_evt_up", 8'(bus.EVT_CNT), 8'd2);
        for (int i = 0; i < DC; i++) begin
            applyStimulus(1'b0, 1'b0, "t3_wait");
            checkValue("t3_no_fall", 8'(bus.FALL), 8'd0);
        end
        applyStimulus(1'b0, 1'b0, "t3_fall");
        checkValue("t3_fall", 8'(bus.FALL), 8'd1);
        checkValue("t3_q", 8'(bus.Q), 8'd0);
        checkValue("t3_evt", 8'(bus.EVT_CNT), 8'd2);
        applyStimulus(1'b0, 1'b0, "t3_after");
        checkValue("t3_fall_once", 8'(bus.FALL), 8'd0);

        // 4: 17 presses from a fresh reset, counter wraps
        doReset("t4_reset");
        for (int p = 0; p < 17; p++) begin
            press("t4_press");
            checkValue("t4_evt", 8'(bus.EVT_CNT), 8'((p + 1) % 16));
        end

        // 5: clear coincident with a rise at EVT_CNT=5
        for (int p = 0; p < 4; p++) press("t5_press");
        checkValue("t5_evt5", 8'(bus.EVT_CNT), 8'd5);
        for (int i = 0; i < DC; i++) applyStimulus(1'b1, 1'b0, "t5_wait");
        applyStimulus(1'b1, 1'b1, "t5_clr_rise");
        checkValue("t5_rise", 8'(bus.RISE), 8'd1);
        checkValue("t5_evt0", 8'(bus.EVT_CNT), 8'd0);
        applyStimulus(1'b1, 1'b0, "t5_after");
        checkValue("t5_evt_hold", 8'(bus.EVT_CNT), 8'd0);

        // 6: reset in WAIT_HI with cnt=2, then requalify with D held high
        for (int i = 0; i < DC + 2; i++) applyStimulus(1'b0, 1'b0, "t6_low");
        press("t6_press");
        checkValue("t6_evt1", 8'(bus.EVT_CNT), 8'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, "t6_wait");
        doReset("t6_reset");
        checkValue("t6_rst_q", 8'(bus.Q), 8'd0);
        checkValue("t6_rst_evt", 8'(bus.EVT_CNT), 8'd0);
        checkValue("t6_rst_pulse", 8'({bus.RISE, bus.FALL}), 8'd0);
        for (int i = 0; i < DC; i++) begin
            applyStimulus(1'b1, 1'b0, "t6_requal");
            checkValue("t6_no_rise", 8'(bus.RISE), 8'd0);
        end
        applyStimulus(1'b1, 1'b0, "t6_rise");
        checkValue("t6_rise", 8'(bus.RISE), 8'd1);
        checkValue("t6_evt", 8'(bus.EVT_CNT), 8'd1);

        // Randomized runs of random length, occasional clears, one reset
        for (int r = 0; r < 60; r++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int j = 0; j < len; j++)
                applyStimulus(v, ($urandom_range(0, 15) == 0), "rand");
            if (r == 30) doReset("rand_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
